urv_mem_arb: RTL and testbench
==============================

Name: urv_mem_arb

Overview:
- Two-requester memory arbiter: the instruction fetch port (ifu) and the load/store port (lsu) share one memory port carrying mem_req_t/mem_resp_t.
- Grants one requester and registers its request onto the memory port, then routes the single memory response back to the owner.
- One transaction is outstanding at a time.
- Sits between the core front-end/LSU and the memory/bus adapter.

Parameters:
- LSU_PRIO_INIT, 1: priority owner after reset. 1 = lsu wins the first tie; 0 = ifu wins the first tie.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  ifu request present
- ifu_req_ready  out  1  ifu request accepted this cycle
- ifu_req  in  $bits(mem_req_t)  ifu request payload
- ifu_resp_valid  out  1  response for ifu; one-cycle pulse, no backpressure
- ifu_resp  out  $bits(mem_resp_t)  response payload
- lsu_req_valid / lsu_req_ready / lsu_req / lsu_resp_valid / lsu_resp: same as the ifu ports, for lsu
- mem_req_valid  out  1  registered request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req  out  $bits(mem_req_t)  registered payload
- mem_resp_valid  in  1  memory response; exactly one per accepted request, reads and writes alike
- mem_resp  in  $bits(mem_resp_t)  response payload

Behaviour:
- Clocking and reset are fixed: one clock (clk); reset (rst) is synchronous and active-high.
- State machine ARB_IDLE, ARB_REQ, ARB_RESP; reset state ARB_IDLE.
- Reset values: mem_req_valid=0, mem_req=0, owner=none, prio=LSU_PRIO_INIT.
- ifu_req_ready, lsu_req_ready, ifu_resp_valid and lsu_resp_valid are combinational and therefore 0 during reset.
- ARB_IDLE:
  - If any *_req_valid, pick a winner and assert its *_req_ready combinationally in the same cycle. The loser's ready stays 0.
  - On the edge: mem_req <= winner payload, mem_req_valid <= 1, owner <= winner, go to ARB_REQ.
  - Latency: requester handshake in cycle N gives mem_req_valid=1 in cycle N+1.
- ARB_REQ:
  - mem_req_valid=1; mem_req is held stable until mem_req_valid & mem_req_ready.
  - On that handshake: mem_req_valid <= 0, go to ARB_RESP.
  - Both *_req_ready are 0.
- ARB_RESP:
  - When mem_resp_valid: owner's *_resp_valid=1 in the same cycle and *_resp=mem_resp (combinational pass-through); go to ARB_IDLE.
  - Non-owner resp_valid stays 0.
  - Waits indefinitely; there is no timeout.
- Minimum occupancy is 3 cycles per transaction (IDLE grant, REQ with ready=1, RESP with resp_valid=1). No grant is issued in the response cycle.
- *_resp payload is 0 whenever *_resp_valid=0.
- mem_resp_valid in ARB_IDLE or ARB_REQ is ignored and must not change state (assertion).
- Requesters keep valid and payload stable until ready. The arbiter samples the payload only in the grant cycle.
- rst asserted in any state returns the block to ARB_IDLE and drops the in-flight transaction. The memory side must be reset together with the arbiter.
- Fixed-priority mode: lsu beats ifu on simultaneous valid; prio register unused.

Optional Feature:
- URV_MEM_ARB_RR_EN defined: round-robin arbitration.
  - On simultaneous valid, the requester indicated by prio wins.
  - After each grant, prio flips to the other requester.
  - A single valid requester is always granted, and prio still flips to the non-granted side.
- Not defined: fixed priority, lsu over ifu; LSU_PRIO_INIT ignored.

Decomposition:
- urv_typedef gains:
  - mem_arb_state_t enum {ARB_IDLE, ARB_REQ, ARB_RESP}
  - mem_arb_owner_t enum {OWN_NONE, OWN_IFU, OWN_LSU}
- Widths come from urv_cfg (MEM_ADDR_W, MEM_MASK_W, MEM_DATA_W).
- One sub-module, urv_arb2: 2-way picker (valid[1:0], prio in, one-hot grant out, plus prio register update). Its round-robin logic is gated by URV_MEM_ARB_RR_EN.

Test Plan:
- Single read: ifu valid, addr 0x100, MEM_READ; mem_req_ready=1; resp 0xDEADBEEF two cycles later -> ifu_req_ready in cycle 0, mem_req_valid in cycle 1, ifu_resp_valid=1 with 0xDEADBEEF; lsu_resp_valid stays 0.
- Contention, fixed priority: ifu and lsu valid in the same cycle -> lsu granted first; ifu granted in the first IDLE cycle after the lsu response.
- Contention with URV_MEM_ARB_RR_EN and LSU_PRIO_INIT=0, both held valid for 4 transactions -> grant order ifu, lsu, ifu, lsu.
- Backpressure: mem_req_ready=0 for 5 cycles -> mem_req_valid held and mem_req unchanged; both req_ready=0; handshake on cycle 6.
- Write: lsu MEM_WRITE, addr 0x200, mask 0xF, data 0x12345678 -> mem_req matches bit-exactly; lsu_resp_valid pulses once on mem_resp_valid.
- Reset mid-op: rst in ARB_RESP -> next cycle ARB_IDLE, mem_req_valid=0; a stray mem_resp_valid produces no *_resp_valid.

Source files
------------

// File: rtl/urv_mem_arb_pkg.sv
// Shared types for the urv memory arbiter: request/response payloads,
// arbiter FSM state and owner encodings, and the grant-to-owner helper.
package urv_mem_arb_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_MASK_W = 4;
    localparam int MEM_DATA_W = 32;

    // Bit positions inside the 2-way grant/valid vectors.
    localparam int ARB_IFU = 0;
    localparam int ARB_LSU = 1;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_op_t;

    typedef struct packed {
        mem_op_t               op;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_MASK_W-1:0] mask;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic [MEM_DATA_W-1:0] rdata;
    } mem_resp_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } mem_arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IFU  = 2'd1,
        OWN_LSU  = 2'd2
    } mem_arb_owner_t;

    // Map a one-hot grant onto the owner that will receive the response.
    function automatic mem_arb_owner_t owner_from_grant(input logic [1:0] grant);
        mem_arb_owner_t own;
        own = OWN_NONE;
        if (grant[ARB_LSU]) begin
            own = OWN_LSU;
        end else if (grant[ARB_IFU]) begin
            own = OWN_IFU;
        end
        return own;
    endfunction

endpackage

// File: rtl/urv_arb2.sv
// Two-way request picker. Produces a one-hot grant from valid[1:0] and the
// priority bit (1 = lsu), plus the priority value to store after a grant.
// Build option URV_MEM_ARB_RR_EN: round-robin; otherwise lsu always wins
// and the priority bit passes through untouched.
module urv_arb2
    import urv_mem_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       prio_i,
    output logic [1:0] grant_o,
    output logic       prio_nxt_o
);

`ifdef URV_MEM_ARB_RR_EN
    // Round-robin: ties go to prio, and prio then points at the side not granted.
    always_comb begin
        grant_o    = 2'b00;
        prio_nxt_o = prio_i;
        if (valid_i == 2'b11) begin
            grant_o = prio_i ? 2'b10 : 2'b01;
        end else begin
            grant_o = valid_i;
        end
        if (grant_o[ARB_LSU]) begin
            prio_nxt_o = 1'b0;
        end else if (grant_o[ARB_IFU]) begin
            prio_nxt_o = 1'b1;
        end
    end
`else
    // Fixed priority: lsu beats ifu; the priority bit is left unchanged.
    always_comb begin
        grant_o    = 2'b00;
        prio_nxt_o = prio_i;
        if (valid_i[ARB_LSU]) begin
            grant_o = 2'b10;
        end else if (valid_i[ARB_IFU]) begin
            grant_o = 2'b01;
        end
    end
`endif

endmodule

// File: rtl/urv_mem_arb.sv
// Memory arbiter between the instruction fetch (ifu) and load/store (lsu)
// ports. One transaction in flight: grant in IDLE, hold a registered request
// in REQ until memory accepts it, route the single response back in RESP.
// Build option URV_MEM_ARB_RR_EN selects round-robin arbitration (see urv_arb2).
// Handshake rule: a transfer happens on a cycle where valid and ready are both
// high; requesters hold valid/payload stable until ready, responses are
// one-cycle pulses with no backpressure.
module urv_mem_arb
    import urv_mem_arb_pkg::*;
#(
    parameter bit LSU_PRIO_INIT = 1'b1
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           ifu_req_valid,
    output logic           ifu_req_ready,
    input  mem_req_t       ifu_req,
    output logic           ifu_resp_valid,
    output mem_resp_t      ifu_resp,

    input  logic           lsu_req_valid,
    output logic           lsu_req_ready,
    input  mem_req_t       lsu_req,
    output logic           lsu_resp_valid,
    output mem_resp_t      lsu_resp,

    output logic           mem_req_valid,
    input  logic           mem_req_ready,
    output mem_req_t       mem_req,
    input  logic           mem_resp_valid,
    input  mem_resp_t      mem_resp,

    output mem_arb_state_t dbg_state_o
);

    mem_arb_state_t state_q, state_d;
    mem_arb_owner_t owner_q, owner_d;
    mem_req_t       mem_req_q, mem_req_d;
    logic           mem_req_valid_q, mem_req_valid_d;
    logic           prio_q, prio_d;

    logic [1:0]     req_valid;
    logic [1:0]     grant;
    logic           prio_nxt;

    assign req_valid = {lsu_req_valid, ifu_req_valid};

    urv_arb2 u_arb2 (
        .valid_i    (req_valid),
        .prio_i     (prio_q),
        .grant_o    (grant),
        .prio_nxt_o (prio_nxt)
    );

    // State, owner, registered memory request and priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ARB_IDLE;
            owner_q         <= OWN_NONE;
            mem_req_q       <= '0;
            mem_req_valid_q <= 1'b0;
            prio_q          <= LSU_PRIO_INIT;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            mem_req_q       <= mem_req_d;
            mem_req_valid_q <= mem_req_valid_d;
            prio_q          <= prio_d;
        end
    end

    // Next-state and handshake outputs; everything combinational is held low in reset.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        mem_req_d       = mem_req_q;
        mem_req_valid_d = mem_req_valid_q;
        prio_d          = prio_q;
        ifu_req_ready   = 1'b0;
        lsu_req_ready   = 1'b0;
        ifu_resp_valid  = 1'b0;
        lsu_resp_valid  = 1'b0;
        ifu_resp        = '0;
        lsu_resp        = '0;

        if (!rst) begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (|grant) begin
                        ifu_req_ready   = grant[ARB_IFU];
                        lsu_req_ready   = grant[ARB_LSU];
                        mem_req_d       = grant[ARB_LSU] ? lsu_req : ifu_req;
                        mem_req_valid_d = 1'b1;
                        owner_d         = owner_from_grant(grant);
                        prio_d          = prio_nxt;
                        state_d         = ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_d = 1'b0;
                        state_d         = ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    // No grant here: a new request waits for the next IDLE cycle.
                    if (mem_resp_valid) begin
                        if (owner_q == OWN_IFU) begin
                            ifu_resp_valid = 1'b1;
                            ifu_resp       = mem_resp;
                        end else if (owner_q == OWN_LSU) begin
                            lsu_resp_valid = 1'b1;
                            lsu_resp       = mem_resp;
                        end
                        owner_d = OWN_NONE;
                        state_d = ARB_IDLE;
                    end
                end
                default: begin
                    state_d         = ARB_IDLE;
                    owner_d         = OWN_NONE;
                    mem_req_valid_d = 1'b0;
                end
            endcase
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req       = mem_req_q;
    assign dbg_state_o   = state_q;

    // A response outside ARB_RESP is ignored and must not move the FSM.
    a_resp_ignored_idle : assert property (@(posedge clk) disable iff (rst)
        (state_q == ARB_IDLE && mem_resp_valid && !ifu_req_valid && !lsu_req_valid)
        |=> (state_q == ARB_IDLE));
    a_resp_ignored_req : assert property (@(posedge clk) disable iff (rst)
        (state_q == ARB_REQ && mem_resp_valid && !mem_req_ready)
        |=> (state_q == ARB_REQ));

endmodule

// File: tb/tb_urv_mem_arb.sv
// Directed bench for urv_mem_arb: reset, single read, contention, backpressure
// with a write, mid-transaction reset, and a four-deep held contention run.
module tb_urv_mem_arb;
  import urv_mem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic           ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  mem_req_t       ifu_req;
  mem_resp_t      ifu_resp;
  logic           lsu_req_valid, lsu_req_ready, lsu_resp_valid;
  mem_req_t       lsu_req;
  mem_resp_t      lsu_resp;
  logic           mem_req_valid, mem_req_ready, mem_resp_valid;
  mem_req_t       mem_req;
  mem_resp_t      mem_resp;
  mem_arb_state_t dbg_state;

  urv_mem_arb #(.LSU_PRIO_INIT(1'b0)) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_req        (ifu_req),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp       (ifu_resp),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_req        (lsu_req),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp       (lsu_resp),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req        (mem_req),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp       (mem_resp),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs);
    logic [127:0] exp_v;
    exp_v = exp_q.pop_front();
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    exp_q.push_back(exp_v);
    chk(tag, obs);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after the rising edge; checks follow after #1.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  mem_req_t req_rd, req_a, req_b, req_wr, req_c;

  initial begin
    req_rd = '{op: MEM_READ,  addr: 32'h100, mask: 4'h0, wdata: 32'h0};
    req_a  = '{op: MEM_READ,  addr: 32'h300, mask: 4'h0, wdata: 32'h0};
    req_b  = '{op: MEM_READ,  addr: 32'h400, mask: 4'h0, wdata: 32'h0};
    req_wr = '{op: MEM_WRITE, addr: 32'h200, mask: 4'hF, wdata: 32'h12345678};
    req_c  = '{op: MEM_READ,  addr: 32'h500, mask: 4'h0, wdata: 32'h0};

    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_req = req_rd;
    lsu_req_valid = 1'b0; lsu_req = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp = '0;

    // ---- reset: readies held low even with a valid request ----
    next_cycle(); next_cycle(); next_cycle();
    settle();
    expect_eq("rst_ifu_ready", ifu_req_ready, 1'b0);
    expect_eq("rst_state", dbg_state, ARB_IDLE);
    expect_eq("rst_mem_valid", mem_req_valid, 1'b0);
    expect_eq("rst_mem_req", mem_req, '0);

    // ---- single ifu read ----
    next_cycle();
    rst = 1'b0; mem_req_ready = 1'b1;
    settle();
    expect_eq("rd_ifu_ready_c0", ifu_req_ready, 1'b1);
    expect_eq("rd_lsu_ready_c0", lsu_req_ready, 1'b0);
    expect_eq("rd_mem_valid_c0", mem_req_valid, 1'b0);
    next_cycle();
    ifu_req_valid = 1'b0;
    settle();
    expect_eq("rd_mem_valid_c1", mem_req_valid, 1'b1);
    expect_eq("rd_mem_req_c1", mem_req, req_rd);
    expect_eq("rd_state_c1", dbg_state, ARB_REQ);
    next_cycle();
    mem_resp_valid = 1'b1; mem_resp = 32'hDEADBEEF;
    settle();
    expect_eq("rd_ifu_resp_valid", ifu_resp_valid, 1'b1);
    expect_eq("rd_ifu_resp", ifu_resp, 32'hDEADBEEF);
    expect_eq("rd_lsu_resp_valid", lsu_resp_valid, 1'b0);
    expect_eq("rd_lsu_resp_zero", lsu_resp, 32'h0);
    expect_eq("rd_mem_valid_c2", mem_req_valid, 1'b0);
    next_cycle();
    mem_resp_valid = 1'b0; mem_resp = '0;
    settle();
    expect_eq("rd_ifu_resp_pulse", ifu_resp_valid, 1'b0);
    expect_eq("rd_state_idle", dbg_state, ARB_IDLE);

    // ---- contention: lsu first (fixed prio, and round-robin after an ifu grant) ----
    ifu_req_valid = 1'b1; ifu_req = req_a;
    lsu_req_valid = 1'b1; lsu_req = req_b;
    settle();
    expect_eq("ct_lsu_ready", lsu_req_ready, 1'b1);
    expect_eq("ct_ifu_ready", ifu_req_ready, 1'b0);
    next_cycle();
    lsu_req_valid = 1'b0;
    settle();
    expect_eq("ct_mem_req_b", mem_req, req_b);
    expect_eq("ct_ifu_wait_req", ifu_req_ready, 1'b0);
    next_cycle();
    mem_resp_valid = 1'b1; mem_resp = 32'h11111111;
    settle();
    expect_eq("ct_lsu_resp_valid", lsu_resp_valid, 1'b1);
    expect_eq("ct_lsu_resp", lsu_resp, 32'h11111111);
    expect_eq("ct_ifu_resp_valid", ifu_resp_valid, 1'b0);
    expect_eq("ct_no_grant_resp", ifu_req_ready, 1'b0);
    next_cycle();
    mem_resp_valid = 1'b0; mem_resp = '0;
    settle();
    expect_eq("ct_ifu_ready_idle", ifu_req_ready, 1'b1);
    next_cycle();
    ifu_req_valid = 1'b0;
    settle();
    expect_eq("ct_mem_req_a", mem_req, req_a);
    next_cycle();
    mem_resp_valid = 1'b1; mem_resp = 32'h22222222;
    settle();
    expect_eq("ct_ifu_resp", ifu_resp, 32'h22222222);
    next_cycle();
    mem_resp_valid = 1'b0; mem_resp = '0;

    // ---- lsu write under backpressure ----
    lsu_req_valid = 1'b1; lsu_req = req_wr; mem_req_ready = 1'b0;
    settle();
    expect_eq("wr_lsu_ready", lsu_req_ready, 1'b1);
    next_cycle();
    lsu_req_valid = 1'b0;
    ifu_req_valid = 1'b1; ifu_req = req_c;
    for (int i = 0; i < 5; i++) begin
      mem_resp_valid = (i == 2);
      mem_resp = (i == 2) ? 32'hBAD0BAD0 : 32'h0;
      settle();
      expect_eq("bp_mem_valid", mem_req_valid, 1'b1);
      expect_eq("bp_mem_req", mem_req, req_wr);
      expect_eq("bp_ifu_ready", ifu_req_ready, 1'b0);
      expect_eq("bp_lsu_ready", lsu_req_ready, 1'b0);
      expect_eq("bp_stray_resp", lsu_resp_valid, 1'b0);
      next_cycle();
    end
    mem_resp_valid = 1'b0; mem_resp = '0;
    mem_req_ready = 1'b1;
    settle();
    expect_eq("bp_c6_state", dbg_state, ARB_REQ);
    expect_eq("bp_c6_mem_req", mem_req, req_wr);
    next_cycle();
    settle();
    expect_eq("bp_after_hs_valid", mem_req_valid, 1'b0);
    expect_eq("bp_after_hs_state", dbg_state, ARB_RESP);
    expect_eq("wr_wait_resp", lsu_resp_valid, 1'b0);
    next_cycle();
    mem_resp_valid = 1'b1; mem_resp = 32'hCAFE0000;
    settle();
    expect_eq("wr_lsu_resp_valid", lsu_resp_valid, 1'b1);
    expect_eq("wr_lsu_resp", lsu_resp, 32'hCAFE0000);
    expect_eq("wr_ifu_resp_valid", ifu_resp_valid, 1'b0);
    next_cycle();
    mem_resp_valid = 1'b0; mem_resp = '0;
    settle();
    expect_eq("wr_resp_pulse", lsu_resp_valid, 1'b0);
    expect_eq("wr_ifu_ready", ifu_req_ready, 1'b1);

    // ---- reset while in ARB_RESP ----
    next_cycle();
    ifu_req_valid = 1'b0;
    next_cycle();
    settle();
    expect_eq("mr_state_resp", dbg_state, ARB_RESP);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    settle();
    expect_eq("mr_state_idle", dbg_state, ARB_IDLE);
    expect_eq("mr_mem_valid", mem_req_valid, 1'b0);
    mem_resp_valid = 1'b1; mem_resp = 32'h55555555;
    settle();
    expect_eq("mr_stray_ifu", ifu_resp_valid, 1'b0);
    expect_eq("mr_stray_lsu", lsu_resp_valid, 1'b0);
    next_cycle();
    mem_resp_valid = 1'b0; mem_resp = '0;
    settle();
    expect_eq("mr_still_idle", dbg_state, ARB_IDLE);

    // ---- held contention over 4 transactions, fresh priority ----
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    ifu_req_valid = 1'b1; ifu_req = req_a;
    lsu_req_valid = 1'b1; lsu_req = req_b;
    for (int k = 0; k < 4; k++) begin
      logic exp_lsu;
`ifdef URV_MEM_ARB_RR_EN
      exp_lsu = (k % 2 == 1);
`else
      exp_lsu = 1'b1;
`endif
      settle();
      expect_eq("hc_lsu_ready", lsu_req_ready, exp_lsu);
      expect_eq("hc_ifu_ready", ifu_req_ready, !exp_lsu);
      next_cycle();
      settle();
      expect_eq("hc_mem_req", mem_req, exp_lsu ? req_b : req_a);
      next_cycle();
      mem_resp_valid = 1'b1; mem_resp = 32'hA0 + k;
      settle();
      expect_eq("hc_lsu_resp_valid", lsu_resp_valid, exp_lsu);
      expect_eq("hc_ifu_resp_valid", ifu_resp_valid, !exp_lsu);
      next_cycle();
      mem_resp_valid = 1'b0; mem_resp = '0;
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
